button_conditioner: RTL and testbench

Input conditioning stage between the board push-buttons (btnU, btnL, btnR, btnD, btnC) and the game controller. Each raw button is synchronized, debounced and edge-detected. A single-key lockout arbiter then emits at most one clean, one-cycle press event per physical press. The controller consumes these events instead of raw pad levels, which removes metastability and bounce from the game logic.

---
 rtl/button_conditioner.sv | 130 +++++++++++++
 tb/tb_button_conditioner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the five board push-buttons for the game controller. Each raw pad
// is synchronized into the clk domain and debounced. A rising edge of the
// debounced level produces a one-cycle press pulse. A single-key lockout
// arbiter turns those pulses into at most one clean event per physical press.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   btnU..btnC raw asynchronous button pads
//   btn_level  debounced levels, [0]=U [1]=L [2]=R [3]=D [4]=C
//   btn_press  one-cycle pulse per debounced rising edge, same bit order
//   evt_valid  one-cycle strobe for an arbitrated press event
//   evt_sel    one-hot button of the event, zero when evt_valid is low
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive mismatching s2 samples needed to accept a
//                    new level (2 .. 2**CNT_W-1)
//   CNT_W            width of each debounce counter
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnC,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic       evt_valid,
  output logic [4:0] evt_sel
);

  localparam int NUM_BTN = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  // Lowest-index set bit wins: U beats L beats R beats D beats C, which matches
  // the controller's own priority order.
  function automatic logic [NUM_BTN-1:0] lowestSet(input logic [NUM_BTN-1:0] v);
    return v & (~v + NUM_BTN'(1));
  endfunction

  logic [NUM_BTN-1:0] rawBtn;
  logic [NUM_BTN-1:0] syncS1;
  logic [NUM_BTN-1:0] syncS2;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] prev;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  state_t             state;

  assign rawBtn = {btnC, btnD, btnR, btnL, btnU};

  // Stage: two-flop synchronizer; nothing downstream looks at syncS1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncS1 <= '0;
      syncS2 <= '0;
    end else begin
      syncS1 <= rawBtn;
      syncS2 <= syncS1;
    end
  end

  // Stage: debounce. The counter tracks consecutive samples where syncS2
  // disagrees with the accepted level; a single agreeing sample restarts it,
  // so any glitch shorter than DEBOUNCE_CYCLES leaves stable untouched. The
  // counter is cleared on acceptance and therefore never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (syncS2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= syncS2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Stage: edge detect on the debounced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= stable;
    end
  end

  assign btn_level = stable;
  assign btn_press = stable & ~prev;

  // Stage: lockout arbiter. Once an event is issued, every further press is
  // swallowed until all buttons read released, so a chord yields one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (btn_press != '0) state <= HELD;
        HELD: if (btn_level == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The event is combinational so it lines up with its btn_press pulse.
  assign evt_valid = (state == IDLE) && (btn_press != '0);
  assign evt_sel   = evt_valid ? lowestSet(btn_press) : '0;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnU, btnL, btnR, btnD, btnC;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic       evt_valid;
  logic [4:0] evt_sel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [4:0] sel;
    int         cyc;
  } exp_t;

  exp_t expQ[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btnU(btnU),
    .btnL(btnL),
    .btnR(btnR),
    .btnD(btnD),
    .btnC(btnC),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .evt_valid(evt_valid),
    .evt_sel(evt_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected event: inputs driven after edge `cyc` reach s1 at the next edge,
  // s2 one edge later, and four mismatching s2 samples later stable rises;
  // the event is visible in the cycle after edge cyc+6.
  task automatic expectEvt(input logic [4:0] sel, input int delay);
    exp_t e;
    e.sel = sel;
    e.cyc = cyc + delay;
    expQ.push_back(e);
  endtask

  // Monitor: every observed event must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (evt_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt sel=%b cycle=%0d", evt_sel, cyc);
      end else begin
        e = expQ.pop_front();
        chk("evt_sel", int'(evt_sel), int'(e.sel));
        chk("evt_cycle", cyc, e.cyc);
      end
    end else if (evt_sel != 5'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_sel got=%b expected=00000 cycle=%0d", evt_sel, cyc);
    end
  end

  initial begin
    rst  = 1'b1;
    btnU = 1'b1; btnL = 1'b1; btnR = 1'b1; btnD = 1'b1; btnC = 1'b1;

    // Reset with every button held high.
    tick(3);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(btn_press), 0);
    chk("rst_valid", int'(evt_valid), 0);
    rst = 1'b0;
    expectEvt(5'b00001, 6);
    tick(1);
    chk("post_rst_level", int'(btn_level), 0);
    chk("post_rst_valid", int'(evt_valid), 0);
    tick(6);
    chk("all_held_level", int'(btn_level), 31);
    btnU = 1'b0; btnL = 1'b0; btnR = 1'b0; btnD = 1'b0; btnC = 1'b0;
    tick(8);
    chk("all_released", int'(btn_level), 0);

    // Clean press on L, then release latency.
    btnL = 1'b1;
    expectEvt(5'b00010, 6);
    tick(10);
    btnL = 1'b0;
    tick(5);
    chk("L_level_still_high", int'(btn_level[1]), 1);
    tick(1);
    chk("L_level_fallen", int'(btn_level[1]), 0);
    tick(3);

    // Bounce on R: 1,0,1,0,1 then steady.
    btnR = 1'b1; tick(1);
    btnR = 1'b0; tick(1);
    btnR = 1'b1; tick(1);
    btnR = 1'b0; tick(1);
    btnR = 1'b1;
    expectEvt(5'b00100, 6);
    tick(10);
    btnR = 1'b0;
    tick(10);

    // Simultaneous D and C: one event for D, C still pulses btn_press.
    btnD = 1'b1; btnC = 1'b1;
    expectEvt(5'b01000, 6);
    tick(6);
    chk("DC_press", int'(btn_press), 24);
    tick(4);
    btnD = 1'b0; btnC = 1'b0;
    tick(10);

    // Lockout: L pressed while U held gives a pulse but no event.
    btnU = 1'b1;
    expectEvt(5'b00001, 6);
    tick(8);
    btnL = 1'b1;
    tick(6);
    chk("lock_L_press", int'(btn_press), 2);
    chk("lock_no_evt", int'(evt_valid), 0);
    tick(2);
    btnU = 1'b0; btnL = 1'b0;
    tick(10);
    btnL = 1'b1;
    expectEvt(5'b00010, 6);
    tick(10);
    btnL = 1'b0;
    tick(10);

    // Reset while C is held in the locked state.
    btnC = 1'b1;
    expectEvt(5'b10000, 6);
    tick(9);
    chk("C_level_held", int'(btn_level), 16);
    rst = 1'b1;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_valid", int'(evt_valid), 0);
    tick(2);
    rst = 1'b0;
    expectEvt(5'b10000, 6);
    tick(1);
    chk("midrst_post_level", int'(btn_level), 0);
    tick(8);
    btnC = 1'b0;
    tick(10);

    chk("scoreboard_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
